// File: rtl/rotate_scheduler_if.sv
// Request/acknowledge bundle between the two operand producers and the shared
// rotate scheduler.
interface rotate_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
);
    logic             ReqA;
    logic [WIDTH-1:0] NumberA;
    logic [CW-1:0]    RangeA;
    logic             ReqB;
    logic [WIDTH-1:0] NumberB;
    logic [CW-1:0]    RangeB;
    logic             AckA;
    logic             AckB;
    logic [WIDTH-1:0] Result;
    logic             Valid;
    logic             Busy;

    modport master (
        output ReqA, NumberA, RangeA, ReqB, NumberB, RangeB,
        input  AckA, AckB, Result, Valid, Busy
    );

    modport slave (
        input  ReqA, NumberA, RangeA, ReqB, NumberB, RangeB,
        output AckA, AckB, Result, Valid, Busy
    );
endinterface

// File: rtl/rotate_scheduler.sv
// Shared one-bit-per-cycle rotate-left engine for two round-robin requesters;
// the result is registered and held until the next completion.
module rotate_scheduler #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input logic               Clock,
    input logic               Reset,
    rotate_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             owner_q, owner_d;   // 0 = A, 1 = B
    logic             prio_q, prio_d;     // requester favoured on a tie
    logic [WIDTH-1:0] result_q, result_d;
    logic             grant_b;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        result_d = result_q;
        grant_b  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ReqA || bus.ReqB) begin
                    grant_b = bus.ReqB && (!bus.ReqA || prio_q);
                    owner_d = grant_b;
                    acc_d   = grant_b ? bus.NumberB : bus.NumberA;
                    count_d = grant_b ? bus.RangeB  : bus.RangeA;
                    state_d = (count_d != '0) ? ROT : DONE;
                end
            end
            ROT: begin
                acc_d   = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Capture on entry to DONE so Result is already registered during the ack cycle.
        if (state_d == DONE && state_q != DONE) result_d = acc_d;
    end

    assign bus.Valid  = (state_q == DONE);
    assign bus.AckA   = (state_q == DONE) && !owner_q;
    assign bus.AckB   = (state_q == DONE) &&  owner_q;
    assign bus.Busy   = (state_q != IDLE);
    assign bus.Result = result_q;
endmodule
